// File: rtl/alu8_arbiter_ctrl_pkg.sv
// Shared types for the two-requester ALU front end: opcodes, FSM states,
// and the requester id type used on the response channel.
package alu8_pkg;

    localparam int ID_W = 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_XOR  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu8_arbiter_ctrl_if.sv
// Command and response bus between the two command masters, the response
// consumer and the ALU front end.
//
// Handshake rules: a command transfers on a rising edge where reqN_valid and
// reqN_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. A master holds its command fields
// stable while valid is high and it is waiting; the front end holds the
// response fields stable while rsp_valid is high and rsp_ready is low.
interface alu8_arbiter_ctrl_if #(
    parameter int CNT_W = 16
);
    import alu8_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_operation;
    logic [7:0]       req0_operand_A;
    logic [7:0]       req0_operand_B;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_operation;
    logic [7:0]       req1_operand_A;
    logic [7:0]       req1_operand_B;

    logic             rsp_valid;
    logic             rsp_ready;
    req_id_t          rsp_id;
    logic [15:0]      result;
    logic             carry_flag;
    logic             zero_flag;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    // Command masters and response consumer side.
    modport master (
        output req0_valid, req0_operation, req0_operand_A, req0_operand_B,
        output req1_valid, req1_operation, req1_operand_A, req1_operand_B,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, result, carry_flag, zero_flag, busy, ops_done
    );

    // Front end side.
    modport slave (
        input  req0_valid, req0_operation, req0_operand_A, req0_operand_B,
        input  req1_valid, req1_operation, req1_operand_A, req1_operand_B,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, result, carry_flag, zero_flag, busy, ops_done
    );

endinterface

// File: rtl/alu8_arbiter_ctrl_core.sv
// Combinational 8-bit ALU. ADD/SUB keep the 9-bit result with bit 8 as
// carry/borrow, MUL keeps the full product, logic ops are zero-extended.
module alu8_core
    import alu8_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] result_o,
    output logic        carry_o,
    output logic        zero_o
);

    logic [8:0] sum;
    logic [8:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    // Opcode decode; the zero flag is taken from the final 16-bit result.
    always_comb begin
        result_o = 16'h0000;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD:  begin
                result_o = {7'b0, sum};
                carry_o  = sum[8];
            end
            OP_SUB:  begin
                result_o = {7'b0, diff};
                carry_o  = diff[8];
            end
            OP_MUL:  result_o = 16'(a_i) * 16'(b_i);
            OP_AND:  result_o = {8'h00, a_i & b_i};
            OP_OR:   result_o = {8'h00, a_i | b_i};
            OP_NAND: result_o = {8'h00, ~(a_i & b_i)};
            OP_NOR:  result_o = {8'h00, ~(a_i | b_i)};
            OP_XOR:  result_o = {8'h00, a_i ^ b_i};
            default: result_o = 16'h0000;
        endcase
        zero_o = (result_o == 16'h0000);
    end

endmodule

// File: rtl/alu8_arbiter_ctrl.sv
// Round-robin front end sharing one ALU between two requesters. One
// operation is in flight at a time: IDLE accepts, EXEC registers the ALU
// output, RESP holds the response until the consumer takes it.
module alu8_arbiter_ctrl
    import alu8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    alu8_arbiter_ctrl_if.slave  bus_if,
    output state_e              state_o
);

    state_e           state_q;
    req_id_t          last_grant_q;
    alu_op_e          op_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    req_id_t          id_q;

    logic             rsp_valid_q;
    req_id_t          rsp_id_q;
    logic [15:0]      result_q;
    logic             carry_q;
    logic             zero_q;
    logic [CNT_W-1:0] ops_done_q;

    logic             grant_valid;
    req_id_t          grant_id;
    logic [2:0]       sel_op;
    logic [7:0]       sel_a;
    logic [7:0]       sel_b;

    logic [15:0]      alu_result;
    logic             alu_carry;
    logic             alu_zero;

    // Arbitration: only in IDLE; on contention the requester that did not
    // win last time is granted.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        if (state_q == ST_IDLE) begin
            if (bus_if.req0_valid && bus_if.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (bus_if.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus_if.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Select the granted requester's command fields for capture.
    always_comb begin
        sel_op = bus_if.req0_operation;
        sel_a  = bus_if.req0_operand_A;
        sel_b  = bus_if.req0_operand_B;
        if (grant_id == 1'b1) begin
            sel_op = bus_if.req1_operation;
            sel_a  = bus_if.req1_operand_A;
            sel_b  = bus_if.req1_operand_B;
        end
    end

    assign bus_if.req0_ready = grant_valid && (grant_id == 1'b0);
    assign bus_if.req1_ready = grant_valid && (grant_id == 1'b1);

    // The ALU only ever sees the captured command.
    alu8_core u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero)
    );

    // Control FSM with registered response fields and completion counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= OP_ADD;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            result_q     <= 16'h0000;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        op_q         <= alu_op_e'(sel_op);
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= alu_result;
                    carry_q     <= alu_carry;
                    zero_q      <= alu_zero;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus_if.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + CNT_W'(1);
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_if.rsp_valid  = rsp_valid_q;
    assign bus_if.rsp_id     = rsp_id_q;
    assign bus_if.result     = result_q;
    assign bus_if.carry_flag = carry_q;
    assign bus_if.zero_flag  = zero_q;
    assign bus_if.busy       = (state_q != ST_IDLE);
    assign bus_if.ops_done   = ops_done_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_alu8_arbiter_ctrl.sv
// Bench for alu8_arbiter_ctrl: directed scenarios plus randomized commands
// checked against an arithmetic reference model and an expected queue.
`timescale 1ns/1ps
module tb_alu8_arbiter_ctrl;
  import alu8_pkg::*;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_e state_dbg;

  alu8_arbiter_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

  alu8_arbiter_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus_if  (bus_if.slave),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_ops   = 0;
  // {id, carry, zero, result[15:0]}
  logic [18:0] exp_q[$];

  // Reference model straight from the arithmetic rules.
  function automatic logic [18:0] ref_rsp(input int id, input logic [2:0] op,
                                          input logic [7:0] a, input logic [7:0] b);
    int ai, bi, r;
    logic c;
    ai = int'(a);
    bi = int'(b);
    c  = 1'b0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 255); end
      3'd1: begin r = (ai - bi) & 511; c = (ai < bi); end
      3'd2: r = ai * bi;
      3'd3: r = ai & bi;
      3'd4: r = ai | bi;
      3'd5: r = (~(ai & bi)) & 255;
      3'd6: r = (~(ai | bi)) & 255;
      default: r = ai ^ bi;
    endcase
    return {id[0], c, (r == 0), r[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      bus_if.req0_valid = v; bus_if.req0_operation = op;
      bus_if.req0_operand_A = a; bus_if.req0_operand_B = b;
    end else begin
      bus_if.req1_valid = v; bus_if.req1_operation = op;
      bus_if.req1_operand_A = a; bus_if.req1_operand_B = b;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    bus_if.rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    exp_ops = 0;
    exp_q.delete();
  endtask

  task automatic get_ready(input int id, output logic r);
    r = (id == 0) ? bus_if.req0_ready : bus_if.req1_ready;
  endtask

  // Issue one command with rsp_ready high; returns the observed response and
  // the number of cycles from the accept cycle to rsp_valid (-1 if no grant).
  task automatic do_op(input int id, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, output logic [18:0] obs, output int lat);
    int n;
    logic r;
    n = 0;
    obs = 'x;
    lat = -1;
    set_req(id, 1'b1, op, a, b);
    #1;
    get_ready(id, r);
    while (!r && n < 40) begin
      tick();
      n++;
      get_ready(id, r);
    end
    if (!r) begin
      set_req(id, 1'b0, op, a, b);
      return;
    end
    tick();
    set_req(id, 1'b0, op, a, b);
    lat = 1;
    while (!bus_if.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (bus_if.rsp_valid) begin
      obs = {bus_if.rsp_id, bus_if.carry_flag, bus_if.zero_flag, bus_if.result};
      exp_ops++;
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus_if.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus_if.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus_if.rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b want 0", bus_if.rsp_id); else pass_cnt++;
    total_cnt++; if (bus_if.result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", bus_if.result); else pass_cnt++;
    total_cnt++; if ({bus_if.carry_flag, bus_if.zero_flag} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {bus_if.carry_flag, bus_if.zero_flag}); else pass_cnt++;
    total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus_if.busy); else pass_cnt++;
    total_cnt++; if (bus_if.ops_done !== '0) $display("FAIL reset_ops_done: got %0d want 0", bus_if.ops_done); else pass_cnt++;
    total_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else pass_cnt++;
    total_cnt++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {bus_if.req0_ready, bus_if.req1_ready}); else pass_cnt++;
  endtask

  task automatic test_add();
    logic [18:0] obs;
    int lat;
    do_op(0, 3'd0, 8'hFF, 8'h01, obs, lat);
    total_cnt++; if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (obs !== 19'({1'b0, 1'b1, 1'b0, 16'h0100})) $display("FAIL add_rsp: got %h want %h", obs, 19'({1'b0, 1'b1, 1'b0, 16'h0100})); else pass_cnt++;
    total_cnt++; if (obs !== ref_rsp(0, 3'd0, 8'hFF, 8'h01)) $display("FAIL add_model: got %h want %h", obs, ref_rsp(0, 3'd0, 8'hFF, 8'h01)); else pass_cnt++;
    total_cnt++; if (bus_if.ops_done !== CNT_W'(1)) $display("FAIL add_ops_done: got %0d want 1", bus_if.ops_done); else pass_cnt++;
    total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL add_busy_after: got %b want 0", bus_if.busy); else pass_cnt++;
  endtask

  task automatic test_sub_mul();
    logic [18:0] obs;
    int lat;
    do_op(1, 3'd1, 8'h05, 8'h07, obs, lat);
    total_cnt++; if (obs !== 19'({1'b1, 1'b1, 1'b0, 16'h01FE})) $display("FAIL sub_rsp: got %h want %h", obs, 19'({1'b1, 1'b1, 1'b0, 16'h01FE})); else pass_cnt++;
    do_op(1, 3'd2, 8'hFF, 8'hFF, obs, lat);
    total_cnt++; if (obs !== 19'({1'b1, 1'b0, 1'b0, 16'hFE01})) $display("FAIL mul_rsp: got %h want %h", obs, 19'({1'b1, 1'b0, 1'b0, 16'hFE01})); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL mul_latency: got %0d want 2", lat); else pass_cnt++;
  endtask

  task automatic test_nand_nor();
    logic [18:0] obs;
    int lat;
    do_op(0, 3'd5, 8'hFF, 8'hFF, obs, lat);
    total_cnt++; if (obs !== 19'({1'b0, 1'b0, 1'b1, 16'h0000})) $display("FAIL nand_rsp: got %h want %h", obs, 19'({1'b0, 1'b0, 1'b1, 16'h0000})); else pass_cnt++;
    do_op(0, 3'd6, 8'h00, 8'h00, obs, lat);
    total_cnt++; if (obs !== 19'({1'b0, 1'b0, 1'b0, 16'h00FF})) $display("FAIL nor_rsp: got %h want %h", obs, 19'({1'b0, 1'b0, 1'b0, 16'h00FF})); else pass_cnt++;
    total_cnt++; if (bus_if.ops_done !== CNT_W'(exp_ops)) $display("FAIL nand_nor_ops_done: got %0d want %0d", bus_if.ops_done, exp_ops); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [2:0] c_op[2];
    logic [7:0] c_a[2];
    logic [7:0] c_b[2];
    int grants[$];
    int done, cyc, g, model_last;
    bit both_seen;
    logic [18:0] got, exp;
    do_reset();
    model_last = 1;
    done = 0; cyc = 0; both_seen = 0;
    for (int i = 0; i < 2; i++) begin
      c_op[i] = 3'($urandom_range(0, 7)); c_a[i] = 8'($urandom); c_b[i] = 8'($urandom);
      set_req(i, 1'b1, c_op[i], c_a[i], c_b[i]);
    end
    while (done < 4 && cyc < 60) begin
      #1;
      g = -1;
      if (bus_if.req0_ready && bus_if.req1_ready) both_seen = 1;
      if (bus_if.req0_ready || bus_if.req1_ready) begin
        g = bus_if.req1_ready ? 1 : 0;
        grants.push_back(g);
        // both requesters always valid, so the model grants the non-last one
        model_last = 1 - model_last;
        exp_q.push_back(ref_rsp(model_last, c_op[model_last], c_a[model_last], c_b[model_last]));
      end
      if (bus_if.rsp_valid) begin
        got = {bus_if.rsp_id, bus_if.carry_flag, bus_if.zero_flag, bus_if.result};
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL contention_rsp: got %h want no response", got);
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) $display("FAIL contention_rsp: got %h want %h", got, exp); else pass_cnt++;
        end
        done++;
        exp_ops++;
      end
      tick();
      if (g >= 0) begin
        c_op[g] = 3'($urandom_range(0, 7)); c_a[g] = 8'($urandom); c_b[g] = 8'($urandom);
        set_req(g, 1'b1, c_op[g], c_a[g], c_b[g]);
      end
      cyc++;
    end
    idle_inputs();
    total_cnt++; if (done !== 4) $display("FAIL contention_count: got %0d want 4", done); else pass_cnt++;
    total_cnt++; if (both_seen !== 1'b0) $display("FAIL contention_both_ready: got %b want 0", both_seen); else pass_cnt++;
    total_cnt++;
    if (grants.size() < 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1)
      $display("FAIL contention_order: got %p want 0,1,0,1", grants);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [2:0] op1, op0;
    logic [7:0] a1, b1, a0, b0;
    logic [18:0] got, exp;
    int n;
    logic r;
    tick();
    op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom);
    op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom);
    bus_if.rsp_ready = 1'b0;
    set_req(1, 1'b1, op1, a1, b1);
    #1;
    n = 0;
    get_ready(1, r);
    while (!r && n < 20) begin tick(); n++; get_ready(1, r); end
    total_cnt++; if (r !== 1'b1) $display("FAIL bp_grant1: got %b want 1", r); else pass_cnt++;
    tick();
    set_req(1, 1'b0, op1, a1, b1);
    set_req(0, 1'b1, op0, a0, b0);
    n = 0;
    while (!bus_if.rsp_valid && n < 20) begin tick(); n++; end
    exp = ref_rsp(1, op1, a1, b1);
    for (int i = 0; i < 5; i++) begin
      got = {bus_if.rsp_id, bus_if.carry_flag, bus_if.zero_flag, bus_if.result};
      total_cnt++; if (bus_if.rsp_valid !== 1'b1) $display("FAIL bp_valid_held: cycle %0d got %b want 1", i, bus_if.rsp_valid); else pass_cnt++;
      total_cnt++; if (got !== exp) $display("FAIL bp_stable: cycle %0d got %h want %h", i, got, exp); else pass_cnt++;
      total_cnt++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) $display("FAIL bp_ready_low: cycle %0d got %b want 00", i, {bus_if.req0_ready, bus_if.req1_ready}); else pass_cnt++;
      total_cnt++; if (bus_if.ops_done !== CNT_W'(exp_ops)) $display("FAIL bp_ops_hold: cycle %0d got %0d want %0d", i, bus_if.ops_done, exp_ops); else pass_cnt++;
      tick();
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    exp_ops++;
    total_cnt++; if (bus_if.ops_done !== CNT_W'(exp_ops)) $display("FAIL bp_ops_inc: got %0d want %0d", bus_if.ops_done, exp_ops); else pass_cnt++;
    total_cnt++; if (bus_if.req0_ready !== 1'b1) $display("FAIL bp_held_cmd_grant: got %b want 1", bus_if.req0_ready); else pass_cnt++;
    tick();
    set_req(0, 1'b0, op0, a0, b0);
    tick();
    got = {bus_if.rsp_id, bus_if.carry_flag, bus_if.zero_flag, bus_if.result};
    exp = ref_rsp(0, op0, a0, b0);
    total_cnt++; if (bus_if.rsp_valid !== 1'b1 || got !== exp) $display("FAIL bp_held_cmd_rsp: got %b/%h want 1/%h", bus_if.rsp_valid, got, exp); else pass_cnt++;
    tick();
    exp_ops++;
  endtask

  task automatic test_reset_in_exec();
    bit seen_rsp;
    do_reset();
    set_req(0, 1'b1, 3'd0, 8'($urandom), 8'($urandom));
    #1;
    total_cnt++; if (bus_if.req0_ready !== 1'b1) $display("FAIL rst_exec_grant: got %b want 1", bus_if.req0_ready); else pass_cnt++;
    tick();
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    total_cnt++; if (state_dbg !== ST_EXEC) $display("FAIL rst_exec_state: got %0d want %0d", state_dbg, ST_EXEC); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.carry_flag, bus_if.zero_flag, bus_if.busy} !== 5'b0 ||
        bus_if.result !== 16'h0000 || bus_if.ops_done !== '0)
      $display("FAIL rst_exec_outputs: got v=%b id=%b c=%b z=%b busy=%b res=%h ops=%0d want all 0",
               bus_if.rsp_valid, bus_if.rsp_id, bus_if.carry_flag, bus_if.zero_flag,
               bus_if.busy, bus_if.result, bus_if.ops_done);
    else pass_cnt++;
    seen_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_if.rsp_valid) seen_rsp = 1;
      tick();
    end
    total_cnt++; if (seen_rsp !== 1'b0) $display("FAIL rst_exec_no_rsp: got %b want 0", seen_rsp); else pass_cnt++;
    set_req(0, 1'b1, 3'd3, 8'h0F, 8'hF0);
    set_req(1, 1'b1, 3'd4, 8'h0F, 8'hF0);
    #1;
    total_cnt++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) $display("FAIL rst_exec_next_grant: got %b want 10", {bus_if.req0_ready, bus_if.req1_ready}); else pass_cnt++;
    // both withdraw before the edge: neither command may be serviced
    idle_inputs();
    seen_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_if.rsp_valid || bus_if.busy) seen_rsp = 1;
    end
    total_cnt++; if (seen_rsp !== 1'b0) $display("FAIL dropped_valid_serviced: got %b want 0", seen_rsp); else pass_cnt++;
  endtask

  task automatic test_wrap_random();
    logic [18:0] obs, exp;
    logic [2:0] op;
    logic [7:0] a, b;
    int lat, id;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      id = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      if (i % 5 == 0) begin a = 8'hFF; b = 8'hFF; end
      do_op(id, op, a, b, obs, lat);
      exp = ref_rsp(id, op, a, b);
      total_cnt++; if (obs !== exp || lat !== 2) $display("FAIL rand_op%0d: got %h lat %0d want %h lat 2", i, obs, lat, exp); else pass_cnt++;
      total_cnt++; if (bus_if.ops_done !== CNT_W'(exp_ops)) $display("FAIL rand_ops_done%0d: got %0d want %0d", i, bus_if.ops_done, exp_ops % (1 << CNT_W)); else pass_cnt++;
      if (exp_ops == (1 << CNT_W)) begin
        total_cnt++; if (bus_if.ops_done !== '0) $display("FAIL ops_wrap: got %0d want 0", bus_if.ops_done); else pass_cnt++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_sub_mul();
    test_nand_nor();
    test_contention();
    test_backpressure();
    test_reset_in_exec();
    test_wrap_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
